micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_seq_pkg.sv | 34 +++
 rtl/iter_counter.sv | 28 ++
 rtl/micro_sequencer.sv | 141 ++++++++++++++
 tb/tb_micro_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/micro_seq_pkg.sv
// Shared encodings for the micro-sequencer: sequencing-field codes, FSM states,
// default microaddresses and the increment-overflow helper.
package micro_seq_pkg;

    localparam int UPC_W = 5;

    localparam logic [UPC_W-1:0] DEF_FETCH_ADDR = 5'b00000;
    localparam logic [UPC_W-1:0] DEF_TRAP_ADDR  = 5'b11111;

    typedef enum logic [2:0] {
        USEQ_NEXT    = 3'b000,
        USEQ_DISP1   = 3'b001,
        USEQ_DISP2   = 3'b010,
        USEQ_FETCH   = 3'b011,
        USEQ_BRZ     = 3'b100,
        USEQ_WAITMEM = 3'b101,
        USEQ_ITER    = 3'b110,
        USEQ_RSVD    = 3'b111
    } useq_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ITER = 2'd1,
        ST_TRAP = 2'd2
    } seq_state_e;

    // An increment is illegal if it would wrap past the top of the micro-ROM
    // or land on the trap vector.
    function automatic logic inc_hits_trap(input logic [UPC_W-1:0] upc,
                                           input logic [UPC_W-1:0] trap_addr);
        return (upc == {UPC_W{1'b1}}) || (UPC_W'(upc + 1'b1) == trap_addr);
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Down-counter that times a multi-cycle ITER microinstruction.
// Loads a fixed start value, decrements to zero and saturates there.
module iter_counter #(
    parameter int           W        = 5,
    parameter logic [W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic is_zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= W'(count_reg - 1'b1);
        end
    end

    assign is_zero = (count_reg == '0);

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects the next micro-ROM address from the useq field,
// stalls on memory and multi-cycle ITER ops, and latches into a sticky trap state.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int               ITER_CYCLES = 32,
    parameter logic [UPC_W-1:0] FETCH_ADDR  = DEF_FETCH_ADDR,
    parameter logic [UPC_W-1:0] TRAP_ADDR   = DEF_TRAP_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       useq,
    input  logic [UPC_W-1:0] disp1_addr,
    input  logic [UPC_W-1:0] disp2_addr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [UPC_W-1:0] upc,
    output logic             instr_done,
    output logic             iter_busy,
    output logic             trap
);

    localparam int             CNT_W     = (ITER_CYCLES > 2) ? $clog2(ITER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ITER_LOAD = CNT_W'(ITER_CYCLES - 2);

    seq_state_e       state_reg, state_next;
    logic [UPC_W-1:0] upc_reg, upc_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic             trap_reg, trap_next;

    logic [UPC_W-1:0] upc_inc;
    logic             take_inc;
    logic             go_trap;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    assign upc_inc = UPC_W'(upc_reg + 1'b1);

    iter_counter #(
        .W        (CNT_W),
        .LOAD_VAL (ITER_LOAD)
    ) u_iter_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .is_zero (cnt_zero)
    );

    always_comb begin
        state_next = state_reg;
        upc_next   = upc_reg;
        done_next  = 1'b0;
        take_inc   = 1'b0;
        go_trap    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state_reg)
            ST_RUN: begin
                case (useq_e'(useq))
                    USEQ_NEXT: take_inc = 1'b1;
                    USEQ_DISP1: begin
                        if (disp1_addr == TRAP_ADDR) go_trap = 1'b1;
                        else                         upc_next = disp1_addr;
                    end
                    USEQ_DISP2: begin
                        if (disp2_addr == TRAP_ADDR) go_trap = 1'b1;
                        else                         upc_next = disp2_addr;
                    end
                    USEQ_FETCH: begin
                        upc_next  = FETCH_ADDR;
                        done_next = 1'b1;
                    end
                    USEQ_BRZ: begin
                        if (zero) begin
                            upc_next  = FETCH_ADDR;
                            done_next = 1'b1;
                        end else begin
                            take_inc = 1'b1;
                        end
                    end
                    USEQ_WAITMEM: take_inc = mem_ready;
                    USEQ_ITER: begin
                        // The entry cycle counts as the first of ITER_CYCLES.
                        state_next = ST_ITER;
                        cnt_load   = 1'b1;
                    end
                    default: go_trap = 1'b1;
                endcase
            end
            ST_ITER: begin
                if (cnt_zero) begin
                    state_next = ST_RUN;
                    take_inc   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: go_trap = 1'b1;
        endcase

        if (take_inc) begin
            if (inc_hits_trap(upc_reg, TRAP_ADDR)) go_trap = 1'b1;
            else                                   upc_next = upc_inc;
        end

        if (go_trap) begin
            state_next = ST_TRAP;
            upc_next   = TRAP_ADDR;
            done_next  = 1'b0;
        end

        busy_next = (state_next == ST_ITER);
        trap_next = (state_next == ST_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            upc_reg   <= FETCH_ADDR;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            trap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            upc_reg   <= upc_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            trap_reg  <= trap_next;
        end
    end

    assign upc        = upc_reg;
    assign instr_done = done_reg;
    assign iter_busy  = busy_reg;
    assign trap       = trap_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed scoreboard bench for micro_sequencer: stimulus pushes expected
// {upc, instr_done, iter_busy, trap} per cycle, a monitor pops and compares.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] useq = 3'b000;
    logic [4:0] disp1_addr = 5'd0;
    logic [4:0] disp2_addr = 5'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [4:0] upc;
    logic       instr_done;
    logic       iter_busy;
    logic       trap;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    micro_sequencer #(
        .ITER_CYCLES (32),
        .FETCH_ADDR  (5'b00000),
        .TRAP_ADDR   (5'b11111)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .useq       (useq),
        .disp1_addr (disp1_addr),
        .disp2_addr (disp2_addr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .upc        (upc),
        .instr_done (instr_done),
        .iter_busy  (iter_busy),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got upc=%0d done=%b busy=%b trap=%b, want upc=%0d done=%b busy=%b trap=%b",
                     nm, act[7:3], act[2], act[1], act[0], exp[7:3], exp[2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: upc=%0d done=%b busy=%b trap=%b", nm, act[7:3], act[2], act[1], act[0]);
        end
    endtask

    // Called at a falling edge: drive inputs, queue the state expected after the next rising edge.
    task automatic step(input string nm, input logic [2:0] us, input logic [4:0] d1, input logic [4:0] d2,
                        input logic z, input logic mr,
                        input logic [4:0] eu, input logic ed, input logic eb, input logic et);
        exp_t e;
        useq       = us;
        disp1_addr = d1;
        disp2_addr = d2;
        zero       = z;
        mem_ready  = mr;
        e.name = nm;
        e.val  = {eu, ed, eb, et};
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_step(input string nm, input logic [4:0] eu, input logic eb, input logic et);
        step(nm, 3'($urandom_range(7, 0)), 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), eu, 1'b0, eb, et);
    endtask

    // Asynchronous reset pulse: checks the outputs mid-cycle, releases on a falling edge.
    task automatic reset_pulse(input string nm);
        rst_n = 1'b0;
        #1;
        check(nm, {upc, instr_done, iter_busy, trap}, {5'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.name, {upc, instr_done, iter_busy, trap}, e.val);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got pending=%0d want 0", sb_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        @(negedge clk);
        #1;
        check("reset_state", {upc, instr_done, iter_busy, trap}, {5'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential NEXT after reset
        step("next0", 3'b000, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
        step("next1", 3'b000, 5'd9, 5'd9, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
        step("next2", 3'b000, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);

        // Fetch, dispatch, fetch with a single-cycle done pulse
        step("fetch_a",  3'b011, 5'd31, 5'd31, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
        step("next_a",   3'b000, 5'd0,  5'd0,  1'b0, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        step("disp1_12", 3'b001, 5'd12, 5'd31, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0, 1'b0);
        step("fetch_b",  3'b011, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
        step("done_off", 3'b000, 5'd0,  5'd0,  1'b0, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);

        // DISP2 ignores disp1, BRZ both ways
        step("disp2_7",  3'b010, 5'd31, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step("brz_nt",   3'b100, 5'd0,  5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        step("brz_tk",   3'b100, 5'd0,  5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("next_z",   3'b000, 5'd0,  5'd0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);

        // WAITMEM stalls four cycles, then advances
        for (int i = 0; i < 4; i++)
            step("wait_hold", 3'b101, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
        step("wait_go", 3'b101, 5'd0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);

        // ITER at upc 18: 31 busy cycles after entry (32 total at upc 18), then 19
        step("disp1_18", 3'b001, 5'd18, 5'd0, 1'b0, 1'b0, 5'd18, 1'b0, 1'b0, 1'b0);
        step("iter_entry", 3'b110, 5'd0, 5'd0, 1'b0, 1'b0, 5'd18, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++)
            rand_step("iter_hold", 5'd18, 1'b1, 1'b0);
        rand_step("iter_exit", 5'd19, 1'b0, 1'b0);
        step("post_iter", 3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0);

        // Increment onto the trap vector
        step("disp2_30", 3'b010, 5'd0, 5'd30, 1'b0, 1'b0, 5'd30, 1'b0, 1'b0, 1'b0);
        step("inc_trap", 3'b000, 5'd0, 5'd0,  1'b0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1);
        step("trap_hold", 3'b011, 5'd0, 5'd0, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1);
        reset_pulse("rst_after_inc");

        // Reserved encoding
        step("rsvd_trap", 3'b111, 5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1);
        reset_pulse("rst_after_rsvd");

        // Dispatch no-match traps and stays trapped under random inputs
        step("disp1_trap", 3'b001, 5'd31, 5'd3, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            rand_step("trap_sticky", 5'd31, 1'b0, 1'b1);
        reset_pulse("rst_clear_trap");
        step("after_trap", 3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
        reset_pulse("rst_idle");

        // Reset in the middle of an ITER
        step("pre_iter0", 3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
        step("pre_iter1", 3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
        step("iter2_entry", 3'b110, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++)
            rand_step("iter2_hold", 5'd2, 1'b1, 1'b0);
        reset_pulse("rst_mid_iter");
        step("rst_next0", 3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
        step("rst_next1", 3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5 && sb_q.size() != 0; i++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got pending=%0d want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
